// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generation and load-use stall control for the EX stage.
// Optional stall statistics counter (stall_cycles) enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
  parameter int REGW     = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic            issue_load,
  input  logic [REGW-1:0] issue_rd,
  input  logic            use_a,
  input  logic            use_b,
  input  logic [REGW-1:0] src_a,
  input  logic [REGW-1:0] src_b,
  input  logic            flush,
  output logic [2:0]      sel_a,
  output logic [2:0]      sel_b,
`ifdef FWD_HAZARD_STATS_EN
  output logic [15:0]     stall_cycles,
`endif
  output logic            stall
);

  typedef struct packed {
    logic            v;
    logic [REGW-1:0] rd;
    logic            ld;
  } stage_t;

  localparam logic [2:0] SEL_RF     = 3'b000;
  localparam logic [2:0] SEL_EXMEM  = 3'b001;
  localparam logic [2:0] SEL_MEM    = 3'b010;
  localparam logic [2:0] SEL_WB     = 3'b011;
  localparam logic [2:0] SEL_MEM_LD = 3'b100;

  localparam logic [1:0] LOAD_CNT = 2'(LOAD_LAT - 1);

  stage_t     ex_q, mem_q, wb_q;
  stage_t     ex_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hazard;

  // Youngest matching producer wins; a load still in EX is skipped here and covered by stall.
  function automatic logic [2:0] fwd_sel(input logic use_x, input logic [REGW-1:0] src_x,
                                         input stage_t ex, input stage_t mem, input stage_t wb);
    logic [2:0] s;
    s = SEL_RF;
    if (!use_x || src_x == '0)              s = SEL_RF;
    else if (ex.v && ex.rd == src_x && !ex.ld) s = SEL_EXMEM;
    else if (mem.v && mem.rd == src_x)      s = mem.ld ? SEL_MEM_LD : SEL_MEM;
    else if (wb.v && wb.rd == src_x)        s = SEL_WB;
    return s;
  endfunction

  always_comb begin
    sel_a = fwd_sel(use_a, src_a, ex_q, mem_q, wb_q);
    sel_b = fwd_sel(use_b, src_b, ex_q, mem_q, wb_q);
  end

  always_comb begin
    hazard = ex_q.v && ex_q.ld && (ex_q.rd != '0) &&
             ((use_a && src_a == ex_q.rd) || (use_b && src_b == ex_q.rd));
    stall  = !flush && (hazard || cnt_q != 2'd0);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush)              cnt_d = 2'd0;
    else if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
    else if (hazard)        cnt_d = LOAD_CNT;
  end

  always_comb begin
    ex_d.v  = issue_valid && issue_we && !stall && !flush;
    ex_d.rd = issue_rd;
    ex_d.ld = issue_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
